// File: rtl/rotate_sequencer.sv
// Multi-cycle right-rotate controller: a per-cycle rotater of at most STEP_MAX bits
// is stepped until the requested amount (mod WIDTH) has been applied.
module rotate_sequencer #(
  parameter int WIDTH    = 8,
  parameter int AMT_BITS = 4,
  parameter int STEP_MAX = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH-1:0]    in_a,
  input  logic [AMT_BITS-1:0] in_shift,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    out,
  output logic                cout,
  output logic                busy
);

  // WIDTH is a power of two, so the low SH_BITS of the amount are the amount mod WIDTH.
  localparam int SH_BITS = $clog2(WIDTH);
  localparam logic [SH_BITS-1:0] STEP_LIM = SH_BITS'(STEP_MAX);
  localparam logic [SH_BITS:0]   W_AMT    = (SH_BITS + 1)'(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_nx;
  logic [WIDTH-1:0]   work, work_nx;
  logic [SH_BITS-1:0] remaining, rem_nx;
  logic               carry, carry_nx;
  logic [WIDTH-1:0]   out_q, out_nx;
  logic               cout_q, cout_nx;

  logic [SH_BITS-1:0] step;
  logic [WIDTH-1:0]   rot;

  assign step = (remaining > STEP_LIM) ? STEP_LIM : remaining;
  // A zero step shifts left by WIDTH, which yields zero, so rot == work.
  assign rot  = (work >> step) | (work << (W_AMT - {1'b0, step}));

  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    state_nx = state;
    work_nx  = work;
    rem_nx   = remaining;
    carry_nx = carry;
    out_nx   = out_q;
    cout_nx  = cout_q;
    case (state)
      IDLE: begin
        if (in_valid) begin
          work_nx  = in_a;
          rem_nx   = SH_BITS'(in_shift);
          carry_nx = 1'b0;
          state_nx = RUN;
        end
      end
      RUN: begin
        work_nx = rot;
        rem_nx  = remaining - step;
        if (step != '0) carry_nx = rot[WIDTH-1];
        // Results are captured only on entry to DONE so out/cout hold between operations.
        if (rem_nx == '0) begin
          state_nx = DONE;
          out_nx   = rot;
          cout_nx  = carry_nx;
        end
      end
      DONE: begin
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      state     <= IDLE;
      work      <= '0;
      remaining <= '0;
      carry     <= 1'b0;
      out_q     <= '0;
      cout_q    <= 1'b0;
    end else begin
      state     <= state_nx;
      work      <= work_nx;
      remaining <= rem_nx;
      carry     <= carry_nx;
      out_q     <= out_nx;
      cout_q    <= cout_nx;
    end
  end

  assign in_ready  = (state == IDLE) && !reset;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign out       = out_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_rotate_sequencer.sv
// Directed bench for rotate_sequencer (WIDTH=8, AMT_BITS=4, STEP_MAX=3): vector table
// plus hand-written backpressure, mid-operation reset and back-to-back sequences.
module tb_rotate_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic [3:0] in_shift;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out;
  logic       cout;
  logic       busy;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  rotate_sequencer #(.WIDTH(8), .AMT_BITS(4), .STEP_MAX(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_shift  (in_shift),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .cout      (cout),
    .busy      (busy)
  );

  typedef struct {
    logic [7:0] a;
    logic [3:0] sh;
    logic [7:0] eo;
    logic       ec;
    int         lat;  // cycles from accept edge to first out_valid cycle
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Issue one op with out_ready=1; all sampling and driving happens on the falling edge.
  task automatic do_op(input vec_t v, input string nm);
    int n;
    @(negedge clk);
    check({nm, " in_ready idle"}, 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    in_a      = v.a;
    in_shift  = v.sh;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    in_a     = ~v.a;
    in_shift = 4'(v.sh + 4'd3);
    n = 1;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({nm, " latency"}, 32'(n), 32'(v.lat));
    check({nm, " out"}, 32'(out), 32'(v.eo));
    check({nm, " cout"}, 32'(cout), 32'(v.ec));
    check({nm, " busy done"}, 32'(busy), 32'd1);
    @(negedge clk);
    check({nm, " back to idle"}, {30'd0, out_valid, in_ready}, 32'd1);
    check({nm, " out held"}, 32'(out), 32'(v.eo));
  endtask

  initial begin
    vec_t bp;
    int   n;
    int   idx;
    int   ridx;
    int   cyc;
    logic acc;
    logic [7:0] b2b_a [2];
    logic [3:0] b2b_s [2];
    logic [7:0] b2b_o [2];
    logic       b2b_c [2];

    vecs[0] = '{8'hF0, 4'd5,  8'h87, 1'b1, 3};
    vecs[1] = '{8'hA5, 4'd0,  8'hA5, 1'b0, 2};
    vecs[2] = '{8'hB4, 4'd6,  8'hD2, 1'b1, 3};
    vecs[3] = '{8'hF0, 4'd8,  8'hF0, 1'b0, 2};
    vecs[4] = '{8'hF0, 4'd9,  8'h78, 1'b0, 2};
    vecs[5] = '{8'h80, 4'd15, 8'h01, 1'b0, 4};
    vecs[6] = '{8'h3C, 4'd2,  8'h0F, 1'b0, 2};
    vecs[7] = '{8'h01, 4'd1,  8'h80, 1'b1, 2};
    vecs[8] = '{8'h0F, 4'd4,  8'hF0, 1'b1, 3};
    vecs[9] = '{8'h81, 4'd3,  8'h30, 1'b0, 2};

    reset = 1'b1; in_valid = 1'b0; in_a = '0; in_shift = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("reset in_ready", 32'(in_ready), 32'd0);
    check("reset outputs", {22'd0, out_valid, busy, cout, out}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("post reset in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 10; i++) do_op(vecs[i], $sformatf("vec%0d", i));

    // Backpressure: result held for 5 cycles while in_valid pulses are refused.
    bp = '{8'h01, 4'd7, 8'h02, 1'b0, 4};
    @(negedge clk);
    in_valid = 1'b1; in_a = bp.a; in_shift = bp.sh; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("bp latency", 32'(n), 32'(bp.lat));
    for (int k = 0; k < 5; k++) begin
      in_valid = k[0];
      in_a     = 8'h55;
      in_shift = 4'd2;
      check($sformatf("bp hold %0d", k), {22'd0, out_valid, in_ready, cout, out}, {22'd0, 2'b10, 1'b0, 8'h02});
      @(negedge clk);
    end
    check("bp still valid", {30'd0, out_valid, busy}, 32'd3);
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("bp release", {29'd0, out_valid, busy, in_ready}, 32'd1);
    @(negedge clk);
    check("bp no stray accept", 32'(busy), 32'd0);

    // Reset in the first RUN cycle abandons the operation.
    in_valid = 1'b1; in_a = 8'h01; in_shift = 4'd7;
    @(negedge clk);
    in_valid = 1'b0;
    check("mid busy", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("mid reset state", {28'd0, in_ready, busy, out_valid, cout}, 32'd0);
    check("mid reset out", 32'(out), 32'd0);
    reset = 1'b0;
    do_op('{8'h80, 4'd1, 8'h40, 1'b0, 2}, "after reset");

    // Back-to-back with in_valid held high across two queued operands.
    b2b_a[0] = 8'h0F; b2b_s[0] = 4'd4; b2b_o[0] = 8'hF0; b2b_c[0] = 1'b1;
    b2b_a[1] = 8'h81; b2b_s[1] = 4'd1; b2b_o[1] = 8'hC0; b2b_c[1] = 1'b1;
    @(negedge clk);
    idx = 0; ridx = 0; cyc = 0;
    in_valid = 1'b1; in_a = b2b_a[0]; in_shift = b2b_s[0]; out_ready = 1'b1;
    while (ridx < 2 && cyc < 50) begin
      acc = in_valid && in_ready;
      @(negedge clk);
      cyc++;
      if (acc) begin
        idx++;
        if (idx < 2) begin
          in_a = b2b_a[idx]; in_shift = b2b_s[idx];
        end else begin
          in_valid = 1'b0;
        end
      end
      if (out_valid) begin
        check($sformatf("b2b%0d out", ridx), 32'(out), 32'(b2b_o[ridx]));
        check($sformatf("b2b%0d cout", ridx), 32'(cout), 32'(b2b_c[ridx]));
        ridx++;
      end
    end
    check("b2b results seen", 32'(ridx), 32'd2);
    check("b2b accepts", 32'(idx), 32'd2);
    in_valid = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
